// File: rtl/bcd_display_ctrl_if.sv
// rtl/bcd_display_ctrl_if.sv - request handshake bundle for the BCD display front end
//
// Purpose: carries one binary conversion request from the producing datapath
//          to bcd_display_ctrl.
// Signals: bin_in    - binary value, sampled on acceptance
//          bin_valid - request is valid
//          bin_ready - converter is idle and will accept a request
//          blank_lz  - leading-zero blanking for this request, sampled on acceptance
// Modports: master drives the request, slave (the converter) drives bin_ready.
interface bcd_display_ctrl_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] bin_in;
    logic             bin_valid;
    logic             bin_ready;
    logic             blank_lz;

    modport master (
        output bin_in,
        output bin_valid,
        output blank_lz,
        input  bin_ready
    );

    modport slave (
        input  bin_in,
        input  bin_valid,
        input  blank_lz,
        output bin_ready
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// rtl/bcd_display_ctrl.sv - sequential binary-to-BCD front end for a 4-digit 7-seg display
//
// Purpose: accepts a binary value, converts it with a shift-add-3 FSM (one bit
//          per cycle), holds the committed digits with optional leading-zero
//          blanking and generates the display scan tick.
// Ports:   clk       - system clock, rising edge
//          reset     - asynchronous active-high reset
//          bus       - request handshake (bin_in/bin_valid/bin_ready/blank_lz)
//          BCD0..3   - thousands..units digit, 4'hF means blank
//          ovf       - last committed value exceeded MAX_VAL
//          done      - one-cycle pulse when new digits are committed
//          scan_tick - one-cycle pulse every SCAN_DIV clocks
module bcd_display_ctrl #(
    parameter int          WIDTH    = 14,
    parameter int unsigned MAX_VAL  = 9999,
    parameter int          SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    bcd_display_ctrl_if.slave   bus,
    output logic [3:0]          BCD0,
    output logic [3:0]          BCD1,
    output logic [3:0]          BCD2,
    output logic [3:0]          BCD3,
    output logic                ovf,
    output logic                done,
    output logic                scan_tick
);

    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam int             PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin_sr;
    logic [15:0]      bcd_work;
    logic [CNT_W-1:0] bit_cnt;
    logic             blank_q;
    logic             ovf_pending;
    logic [PRE_W-1:0] pre_cnt;

    logic [15:0]      bcd_adj;
    logic [3:0]       dig_th, dig_hu, dig_te, dig_un;

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 4; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digits to commit: overflow forces all blank; blanking ripples from the
    // thousands digit down but never reaches the units digit.
    always_comb begin
        dig_th = bcd_work[15:12];
        dig_hu = bcd_work[11:8];
        dig_te = bcd_work[7:4];
        dig_un = bcd_work[3:0];
        if (ovf_pending) begin
            dig_th = 4'hF;
            dig_hu = 4'hF;
            dig_te = 4'hF;
            dig_un = 4'hF;
        end else if (blank_q && bcd_work[15:12] == 4'd0) begin
            dig_th = 4'hF;
            if (bcd_work[11:8] == 4'd0) begin
                dig_hu = 4'hF;
                if (bcd_work[7:4] == 4'd0) begin
                    dig_te = 4'hF;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.bin_ready <= 1'b0;
            bin_sr        <= '0;
            bcd_work      <= '0;
            bit_cnt       <= '0;
            blank_q       <= 1'b0;
            ovf_pending   <= 1'b0;
            BCD0          <= 4'h0;
            BCD1          <= 4'h0;
            BCD2          <= 4'h0;
            BCD3          <= 4'h0;
            ovf           <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.bin_ready <= 1'b1;
                    if (bus.bin_valid && bus.bin_ready) begin
                        bin_sr        <= bus.bin_in;
                        blank_q       <= bus.blank_lz;
                        ovf_pending   <= (32'(bus.bin_in) > MAX_VAL);
                        bcd_work      <= '0;
                        bit_cnt       <= '0;
                        bus.bin_ready <= 1'b0;
                        state         <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_work, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                    bit_cnt            <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    BCD0          <= dig_th;
                    BCD1          <= dig_hu;
                    BCD2          <= dig_te;
                    BCD3          <= dig_un;
                    ovf           <= ovf_pending;
                    done          <= 1'b1;
                    bus.bin_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.bin_ready <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running scan prescaler, independent of the conversion FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign scan_tick = (pre_cnt == PRE_LAST);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb/tb_bcd_display_ctrl.sv - self-checking bench for bcd_display_ctrl
module tb_bcd_display_ctrl;

    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;
    localparam int LATENCY  = WIDTH + 1;

    logic       clk;
    logic       reset;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic       ovf, done, scan_tick;

    bcd_display_ctrl_if #(.WIDTH(WIDTH)) bus ();

    bcd_display_ctrl #(
        .WIDTH   (WIDTH),
        .MAX_VAL (9999),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .BCD0     (BCD0),
        .BCD1     (BCD1),
        .BCD2     (BCD2),
        .BCD3     (BCD3),
        .ovf      (ovf),
        .done     (done),
        .scan_tick(scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by plain arithmetic, packed {ovf, BCD0..BCD3}.
    function automatic logic [16:0] model(input int v, input bit b);
        logic [3:0] th, hu, te, un;
        if (v > 9999) return {1'b1, 16'hFFFF};
        th = 4'(v / 1000);
        hu = 4'((v / 100) % 10);
        te = 4'((v / 10) % 10);
        un = 4'(v % 10);
        if (b && v < 1000) th = 4'hF;
        if (b && v < 100)  hu = 4'hF;
        if (b && v < 10)   te = 4'hF;
        return {1'b0, th, hu, te, un};
    endfunction

    function automatic logic [16:0] outs();
        return {ovf, BCD0, BCD1, BCD2, BCD3};
    endfunction

    // Scan tick model: counts edges since reset release.
    int  scan_edges = 0;
    bit  scan_chk   = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) scan_edges = 0;
        else       scan_edges = scan_edges + 1;
    end
    always @(negedge clk) begin
        if (scan_chk)
            chk("scan_tick", 32'(scan_tick), 32'(!reset && (scan_edges % SCAN_DIV) == SCAN_DIV - 1));
    end

    logic [16:0] exp_last;

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.bin_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bin_ready) chk({name, "_ready_timeout"}, 32'(bus.bin_ready), 32'd1);
    endtask

    // One conversion; checks latency, busy, held digits, ready and done shape.
    task automatic run_conv(input string name, input int v, input bit b, input bit pulse,
                            output logic [16:0] got);
        int lat = 0;
        bit hold_ok = 1;
        wait_ready(name);
        bus.bin_in    = 14'(v);
        bus.blank_lz  = b;
        bus.bin_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bin_valid = 1'b0;
        bus.bin_in    = 14'($urandom);
        bus.blank_lz  = 1'($urandom);
        chk({name, "_busy_ready"}, 32'(bus.bin_ready), 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (outs() !== exp_last) hold_ok = 0;
            bus.bin_valid = pulse && n >= 2 && n <= 12;
            bus.bin_in    = 14'd1111;
        end
        bus.bin_valid = 1'b0;
        got = outs();
        chk({name, "_latency"}, 32'(lat), 32'(LATENCY));
        chk({name, "_hold"}, 32'(hold_ok), 32'd1);
        chk({name, "_ready_after"}, 32'(bus.bin_ready), 32'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        exp_last = model(v, b);
    endtask

    typedef struct {
        int          val;
        bit          blank;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs [11];
    logic [16:0] got;

    initial begin
        vecs[0]  = '{1234,  1'b0, {1'b0, 4'd1, 4'd2, 4'd3, 4'd4}};
        vecs[1]  = '{9999,  1'b0, {1'b0, 4'd9, 4'd9, 4'd9, 4'd9}};
        vecs[2]  = '{10000, 1'b0, {1'b1, 4'hF, 4'hF, 4'hF, 4'hF}};
        vecs[3]  = '{16383, 1'b1, {1'b1, 4'hF, 4'hF, 4'hF, 4'hF}};
        vecs[4]  = '{7,     1'b1, {1'b0, 4'hF, 4'hF, 4'hF, 4'd7}};
        vecs[5]  = '{0,     1'b1, {1'b0, 4'hF, 4'hF, 4'hF, 4'd0}};
        vecs[6]  = '{1005,  1'b1, {1'b0, 4'd1, 4'd0, 4'd0, 4'd5}};
        vecs[7]  = '{40,    1'b1, {1'b0, 4'hF, 4'hF, 4'd4, 4'd0}};
        vecs[8]  = '{0,     1'b0, {1'b0, 4'd0, 4'd0, 4'd0, 4'd0}};
        vecs[9]  = '{305,   1'b1, {1'b0, 4'hF, 4'd3, 4'd0, 4'd5}};
        vecs[10] = '{8,     1'b0, {1'b0, 4'd0, 4'd0, 4'd0, 4'd8}};

        reset         = 1'b1;
        bus.bin_in    = '0;
        bus.bin_valid = 1'b0;
        bus.blank_lz  = 1'b0;
        exp_last      = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_ready", 32'(bus.bin_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_scan", 32'(scan_tick), 32'd0);
        reset    = 1'b0;
        scan_chk = 1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.bin_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_conv("vec", vecs[i].val, vecs[i].blank, 1'b0, got);
            chk($sformatf("vec%0d_digits", i), 32'(got), 32'(vecs[i].exp));
        end

        // Busy-time valid pulses carrying another value must be ignored.
        run_conv("pulse", 5555, 1'b0, 1'b1, got);
        chk("pulse_digits", 32'(got), 32'(model(5555, 0)));
        begin
            int extra = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("pulse_no_extra_done", 32'(extra), 32'd0);
            chk("pulse_digits_kept", 32'(outs()), 32'(model(5555, 0)));
        end

        // Valid held high across two requests: back-to-back, 16 cycles apart.
        begin
            int dn [$];
            wait_ready("hold");
            bus.bin_in    = 14'd12;
            bus.blank_lz  = 1'b0;
            bus.bin_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.bin_in = 14'd34;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (n == 16) bus.bin_valid = 1'b0;
                if (done) begin
                    dn.push_back(n);
                    if (dn.size() == 1) chk("hold_first_digits", 32'(outs()), 32'(model(12, 0)));
                    else                chk("hold_second_digits", 32'(outs()), 32'(model(34, 0)));
                end
            end
            bus.bin_valid = 1'b0;
            chk("hold_done_count", 32'(dn.size()), 32'd2);
            if (dn.size() == 2) begin
                chk("hold_first_at", 32'(dn[0]), 32'(LATENCY));
                chk("hold_spacing", 32'(dn[1] - dn[0]), 32'(LATENCY + 1));
            end
            exp_last = model(34, 0);
        end

        // Reset mid-conversion aborts without a done pulse.
        run_conv("pre_rst", 1234, 1'b0, 1'b0, got);
        chk("pre_rst_digits", 32'(got), 32'(model(1234, 0)));
        wait_ready("abort");
        bus.bin_in    = 14'd5678;
        bus.blank_lz  = 1'b0;
        bus.bin_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bin_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outs", 32'(outs()), 32'd0);
        chk("abort_ready", 32'(bus.bin_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_last = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        begin
            int extra = 0;
            for (int n = 0; n < 25; n++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("abort_no_done", 32'(extra), 32'd0);
            chk("abort_digits_zero", 32'(outs()), 32'd0);
        end
        run_conv("post_rst", 42, 1'b0, 1'b0, got);
        chk("post_rst_digits", 32'(got), 32'(model(42, 0)));

        // Randomized values against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            int v;
            bit b;
            v = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
            if (i % 5 == 1) v = int'($urandom_range(0, 120));
            b = 1'($urandom);
            run_conv("rand", v, b, 1'($urandom), got);
            chk($sformatf("rand_%0d_b%0d", v, b), 32'(got), 32'(model(v, b)));
        end

        scan_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
